// File: rtl/overcooked_pkg.sv
// overcooked_pkg: item codes and serving-space state shared by the kitchen blocks.
package overcooked_pkg;
  typedef logic [3:0] item_t;
  localparam item_t ITEM_EMPTY       = 4'd0;
  localparam item_t ITEM_SOUP_PLATED = 4'd4;
  localparam item_t ITEM_DIRTY_PLATE = 4'd9;
  typedef enum logic [1:0] {EMPTY, FULL, RETURNING, PLATE} slot_state_t;
endpackage

// File: rtl/counter_slot.sv
// counter_slot: one serving space - state, held item, plate-return countdown and consume detect.
module counter_slot
  import overcooked_pkg::*;
#(
  parameter int    PLATE_RETURN = 25175000*5,
  parameter item_t SERVE_ITEM   = ITEM_SOUP_PLATED,
  parameter item_t DIRTY_PLATE  = ITEM_DIRTY_PLATE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_place,
  input  logic        i_take,
  input  item_t       i_item,
  input  item_t       i_ret,
  output slot_state_t o_state,
  output item_t       o_item,
  output item_t       o_check,
  output logic        o_consume
);
  localparam int CW = $clog2(PLATE_RETURN + 1);
  slot_state_t r_state;
  item_t       r_item;
  item_t       r_prev;
  logic [CW-1:0] r_cnt;
  // The checker clears a soup by returning 0 after having seen it on the previous cycle.
  assign o_consume = i_ret == ITEM_EMPTY && r_prev == SERVE_ITEM && r_state == FULL && r_item == SERVE_ITEM;
  assign o_state   = r_state;
  assign o_item    = r_item;
  assign o_check   = (r_state == FULL || r_state == PLATE) ? r_item : ITEM_EMPTY;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_item  <= ITEM_EMPTY;
      r_prev  <= ITEM_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_prev <= i_ret;
      if (o_consume) begin
        r_state <= RETURNING;
        r_cnt   <= CW'(PLATE_RETURN - 1);
      end else if (r_state == RETURNING) begin
        if (r_cnt == '0) begin
          r_state <= PLATE;
          r_item  <= DIRTY_PLATE;
        end else r_cnt <= r_cnt - CW'(1);
      end else if (i_place) begin
        r_state <= FULL;
        r_item  <= i_item;
      end else if (i_take) r_state <= EMPTY;
    end
  end
endmodule

// File: rtl/serving_window.sv
// serving_window: two serving spaces with per-player place/take arbitration and a served-dish count.
module serving_window
  import overcooked_pkg::*;
#(
  parameter int    PLATE_RETURN = 25175000*5,
  parameter item_t SERVE_ITEM   = ITEM_SOUP_PLATED,
  parameter item_t DIRTY_PLATE  = ITEM_DIRTY_PLATE
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            timer_go,
  input  logic [1:0]      act_valid,
  input  logic [1:0]      act_space,
  input  logic [1:0][3:0] act_hand,
  input  logic [1:0][3:0] ret_spaces,
  output logic [1:0][3:0] check_spaces,
  output logic [1:0]      act_done,
  output logic [1:0]      act_accept,
  output logic [1:0][3:0] act_new_hand,
  output logic [7:0]      served_count
);
  slot_state_t     w_state [2];
  item_t           w_item [2];
  item_t           w_put [2];
  logic [1:0]      w_consume, w_place, w_take, w_ok;
  logic [1:0][3:0] w_new_hand;
  logic            w_contest;
  logic            r_prio;
  logic [1:0]      r_done, r_accept;
  logic [1:0][3:0] r_new_hand;
  logic [7:0]      r_served;
  always_comb begin
    w_contest = &act_valid && act_space[0] == act_space[1];
    w_place   = '0;
    w_take    = '0;
    w_put[0]  = ITEM_EMPTY;
    w_put[1]  = ITEM_EMPTY;
    // A pending consume blocks a take on the same space so the soup is never handed back.
    for (int p = 0; p < 2; p++) begin
      w_ok[p] = act_valid[p] && timer_go && !(w_contest && r_prio == (p == 0)) &&
                (act_hand[p] != ITEM_EMPTY ? w_state[act_space[p]] == EMPTY
                 : (w_state[act_space[p]] == FULL || w_state[act_space[p]] == PLATE) && !w_consume[act_space[p]]);
      w_new_hand[p] = !act_valid[p] ? ITEM_EMPTY : !w_ok[p] ? act_hand[p]
                      : act_hand[p] != ITEM_EMPTY ? ITEM_EMPTY : w_item[act_space[p]];
    end
    for (int p = 0; p < 2; p++) begin
      if (w_ok[p]) begin
        w_place[act_space[p]] = act_hand[p] != ITEM_EMPTY;
        w_take[act_space[p]]  = act_hand[p] == ITEM_EMPTY;
        w_put[act_space[p]]   = act_hand[p];
      end
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_slot
    counter_slot #(
      .PLATE_RETURN(PLATE_RETURN),
      .SERVE_ITEM  (SERVE_ITEM),
      .DIRTY_PLATE (DIRTY_PLATE)
    ) u_slot (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_place  (w_place[g]),
      .i_take   (w_take[g]),
      .i_item   (w_put[g]),
      .i_ret    (ret_spaces[g]),
      .o_state  (w_state[g]),
      .o_item   (w_item[g]),
      .o_check  (check_spaces[g]),
      .o_consume(w_consume[g])
    );
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prio     <= 1'b0;
      r_done     <= '0;
      r_accept   <= '0;
      r_new_hand <= '0;
      r_served   <= '0;
    end else begin
      r_prio     <= w_contest ? ~r_prio : r_prio;
      r_done     <= act_valid;
      r_accept   <= w_ok;
      r_new_hand <= w_new_hand;
      r_served   <= r_served + 8'(w_consume[0]) + 8'(w_consume[1]);
    end
  end
  assign act_done     = r_done;
  assign act_accept   = r_accept;
  assign act_new_hand = r_new_hand;
  assign served_count = r_served;
endmodule

// File: tb/tb_serving_window.sv
// tb_serving_window: directed scenarios for serving_window with a short plate-return time.
module tb_serving_window;
  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            timer_go = 1'b0;
  logic [1:0]      act_valid = '0;
  logic [1:0]      act_space = '0;
  logic [1:0][3:0] act_hand = '0;
  logic [1:0][3:0] ret_spaces = '0;
  logic [1:0][3:0] check_spaces;
  logic [1:0]      act_done, act_accept;
  logic [1:0][3:0] act_new_hand;
  logic [7:0]      served_count;
  int vectors = 0;
  int miscompares = 0;

  serving_window #(.PLATE_RETURN(5)) dut (
    .clock(clock), .reset_n(reset_n), .timer_go(timer_go),
    .act_valid(act_valid), .act_space(act_space), .act_hand(act_hand),
    .ret_spaces(ret_spaces), .check_spaces(check_spaces), .act_done(act_done),
    .act_accept(act_accept), .act_new_hand(act_new_hand), .served_count(served_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] sp, input logic [3:0] h1, input logic [3:0] h0);
    act_valid = v;
    act_space = sp;
    act_hand  = {h1, h0};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    repeat (2) tick();
    vectors++;
    if ({check_spaces, act_done, act_accept, act_new_hand, served_count} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want 0", {check_spaces, act_done, act_accept, act_new_hand, served_count});
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({check_spaces, act_done, act_accept, act_new_hand, served_count} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_release: got %h want 0", {check_spaces, act_done, act_accept, act_new_hand, served_count});
    end
  endtask

  task automatic test_place();
    timer_go = 1'b1;
    drive(2'b01, 2'b01, 4'd0, 4'd4);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand} !== {2'b01, 2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL place_resp: got %h want %h", {act_done, act_accept, act_new_hand}, {2'b01, 2'b01, 8'h00});
    end
    vectors++;
    if (check_spaces !== 8'h40) begin
      miscompares++;
      $display("FAIL place_space: got %h want 40", check_spaces);
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    tick();
    vectors++;
    if (act_done !== 2'b00) begin
      miscompares++;
      $display("FAIL done_pulse: got %b want 00", act_done);
    end
  endtask

  task automatic test_serve();
    ret_spaces = 8'h40;
    tick();
    ret_spaces = 8'h00;
    tick();
    vectors++;
    if (served_count !== 8'd1) begin
      miscompares++;
      $display("FAIL serve_count: got %0d want 1", served_count);
    end
    vectors++;
    if (check_spaces !== 8'h00) begin
      miscompares++;
      $display("FAIL returning_0: got %h want 00", check_spaces);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      vectors++;
      if (check_spaces !== 8'h00) begin
        miscompares++;
        $display("FAIL returning_%0d: got %h want 00", i, check_spaces);
      end
    end
    tick();
    vectors++;
    if (check_spaces !== 8'h90) begin
      miscompares++;
      $display("FAIL plate_appears: got %h want 90", check_spaces);
    end
    drive(2'b10, 2'b10, 4'd0, 4'd0);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand} !== {2'b10, 2'b10, 8'h90}) begin
      miscompares++;
      $display("FAIL take_plate: got %h want %h", {act_done, act_accept, act_new_hand}, {2'b10, 2'b10, 8'h90});
    end
    vectors++;
    if (check_spaces !== 8'h00) begin
      miscompares++;
      $display("FAIL take_plate_space: got %h want 00", check_spaces);
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    tick();
  endtask

  task automatic test_contention();
    drive(2'b11, 2'b00, 4'd3, 4'd2);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand, check_spaces} !== {2'b11, 2'b01, 8'h30, 8'h02}) begin
      miscompares++;
      $display("FAIL contend_p0: got %h want %h", {act_done, act_accept, act_new_hand, check_spaces}, {2'b11, 2'b01, 8'h30, 8'h02});
    end
    drive(2'b11, 2'b00, 4'd0, 4'd0);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand, check_spaces} !== {2'b11, 2'b10, 8'h20, 8'h00}) begin
      miscompares++;
      $display("FAIL contend_p1: got %h want %h", {act_done, act_accept, act_new_hand, check_spaces}, {2'b11, 2'b10, 8'h20, 8'h00});
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(2'b11, 2'b10, 4'd6, 4'd5);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand, check_spaces} !== {2'b11, 2'b11, 8'h00, 8'h65}) begin
      miscompares++;
      $display("FAIL split_place: got %h want %h", {act_done, act_accept, act_new_hand, check_spaces}, {2'b11, 2'b11, 8'h00, 8'h65});
    end
    drive(2'b11, 2'b10, 4'd0, 4'd0);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand, check_spaces} !== {2'b11, 2'b11, 8'h65, 8'h00}) begin
      miscompares++;
      $display("FAIL split_take: got %h want %h", {act_done, act_accept, act_new_hand, check_spaces}, {2'b11, 2'b11, 8'h65, 8'h00});
    end
    drive(2'b11, 2'b11, 4'd8, 4'd7);
    tick();
    vectors++;
    if ({act_accept, act_new_hand, check_spaces} !== {2'b01, 8'h80, 8'h70}) begin
      miscompares++;
      $display("FAIL prio_not_toggled: got %h want %h", {act_accept, act_new_hand, check_spaces}, {2'b01, 8'h80, 8'h70});
    end
    drive(2'b01, 2'b01, 4'd0, 4'd0);
    tick();
    vectors++;
    if ({act_accept, act_new_hand, check_spaces} !== {2'b01, 8'h07, 8'h00}) begin
      miscompares++;
      $display("FAIL take_back: got %h want %h", {act_accept, act_new_hand, check_spaces}, {2'b01, 8'h07, 8'h00});
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    tick();
  endtask

  task automatic test_consume_vs_take();
    drive(2'b01, 2'b00, 4'd0, 4'd4);
    tick();
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    ret_spaces = 8'h04;
    tick();
    ret_spaces = 8'h00;
    drive(2'b01, 2'b00, 4'd0, 4'd0);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand, check_spaces} !== {2'b01, 2'b00, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL consume_wins: got %h want %h", {act_done, act_accept, act_new_hand, check_spaces}, {2'b01, 2'b00, 8'h00, 8'h00});
    end
    vectors++;
    if (served_count !== 8'd2) begin
      miscompares++;
      $display("FAIL consume_count: got %0d want 2", served_count);
    end
  endtask

  task automatic test_timer_go();
    timer_go = 1'b0;
    drive(2'b10, 2'b10, 4'd3, 4'd0);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand, check_spaces} !== {2'b10, 2'b00, 8'h30, 8'h00}) begin
      miscompares++;
      $display("FAIL timer_off_place: got %h want %h", {act_done, act_accept, act_new_hand, check_spaces}, {2'b10, 2'b00, 8'h30, 8'h00});
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    tick();
    timer_go = 1'b1;
    drive(2'b01, 2'b00, 4'd0, 4'd2);
    tick();
    vectors++;
    if ({act_done, act_accept, act_new_hand} !== {2'b01, 2'b00, 8'h02}) begin
      miscompares++;
      $display("FAIL place_returning: got %h want %h", {act_done, act_accept, act_new_hand}, {2'b01, 2'b00, 8'h02});
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    tick();
    vectors++;
    if (check_spaces !== 8'h00) begin
      miscompares++;
      $display("FAIL late_returning: got %h want 00", check_spaces);
    end
    tick();
    vectors++;
    if (check_spaces !== 8'h09) begin
      miscompares++;
      $display("FAIL plate_timer_off: got %h want 09", check_spaces);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 2'b10, 4'd4, 4'd0);
    tick();
    drive(2'b00, 2'b00, 4'd0, 4'd0);
    ret_spaces = 8'h40;
    tick();
    ret_spaces = 8'h00;
    tick();
    vectors++;
    if ({served_count, check_spaces} !== {8'd3, 8'h09}) begin
      miscompares++;
      $display("FAIL pre_reset: got %h want %h", {served_count, check_spaces}, {8'd3, 8'h09});
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({check_spaces, act_done, act_accept, act_new_hand, served_count} !== 28'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", {check_spaces, act_done, act_accept, act_new_hand, served_count});
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (check_spaces !== 8'h00) begin
        miscompares++;
        $display("FAIL no_plate_%0d: got %h want 00", i, check_spaces);
      end
    end
  endtask

  initial begin
    test_reset();
    test_place();
    test_serve();
    test_contention();
    test_back_to_back();
    test_consume_vs_take();
    test_timer_go();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
